wb_sram_bist_master: RTL and testbench

Wishbone classic initiator that exercises the user-area SRAM bank from inside the user project. On `start` it writes a pseudo-random 32-bit pattern to `count` consecutive words from `base_addr`. It then reads them back and compares each word against the regenerated pattern, reporting pass/fail, the error count and the first failing address. It sits beside the SRAM Wishbone responder; in the wrapper, its master port is muxed onto the responder's slave port. Its control and status are driven from logic-analyzer probes.

---
 rtl/sram_bist_pkg.sv | 34 +++
 rtl/sram_bist_lfsr.sv | 28 ++
 rtl/wb_sram_bist_master.sv | 222 ++++++++++++++++++++++
 tb/tb_wb_sram_bist_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the Wishbone SRAM BIST master.
// Holds the FSM state encoding, the LFSR polynomial and the step function
// used by both the pattern generator and the master.
package sram_bist_pkg;

   // Top-level sequencing states of the BIST master.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR_REQ = 3'd1,
      ST_WR_GAP = 3'd2,
      ST_RD_REQ = 3'd3,
      ST_RD_GAP = 3'd4,
      ST_FIN    = 3'd5
   } bist_state_e;

   // Galois LFSR feedback taps (shift right form).
   localparam logic [31:0] LFSR_POLY       = 32'h8020_0003;
   // An all-zero LFSR would lock up, so a zero seed is replaced by this.
   localparam logic [31:0] LFSR_SEED_FIX   = 32'h0000_0001;
   // Every access is a full 32-bit word.
   localparam logic [3:0]  WB_SEL_ALL      = 4'hF;
   // Byte distance between consecutive test words.
   localparam logic [31:0] WORD_STRIDE     = 32'd4;
   // Clears the byte-offset bits of a byte address.
   localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
   // Saturation point of the mismatch counter.
   localparam logic [15:0] ERR_COUNT_MAX   = 16'hFFFF;

   // One Galois step: shift right, fold the taps in when a 1 falls out.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/sram_bist_lfsr.sv
// 32-bit Galois LFSR pattern generator for the SRAM BIST master.
// The same seed regenerates the identical sequence for the read-back pass.
// A zero seed is replaced by LFSR_SEED_FIX so the register never locks up.
module sram_bist_lfsr
   import sram_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        advance,
   output logic [31:0] value
);

   // Pattern register: load has priority over advance.
   // NOTE: reset is synchronous and active-low, so rst is sampled only
   // inside the clocked block and never appears in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst) begin
         value <= 32'h0;
      end else if (load) begin
         value <= (seed == 32'h0) ? LFSR_SEED_FIX : seed;
      end else if (advance) begin
         value <= lfsr_step(value);
      end
   end

endmodule

// File: rtl/wb_sram_bist_master.sv
// Wishbone classic initiator that writes an LFSR pattern to a block of
// SRAM words, reads it back and reports pass/fail, the mismatch count and
// the first failing byte address.
// Optional feature macro: WB_TIMEOUT_EN -- when defined, a request that sees
// no ack within TIMEOUT_CYCLES cycles is abandoned and flagged in `timeout`.
module wb_sram_bist_master
   import sram_bist_pkg::*;
#(
   parameter int unsigned COUNT_W        = 12,
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic               clk,
   input  logic               rst,
   // Control from the logic-analyzer probes
   input  logic               start,
   input  logic [31:0]        base_addr,
   input  logic [COUNT_W-1:0] count,
   input  logic [31:0]        seed,
   // Wishbone master port
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [3:0]         wbm_sel_o,
   output logic [31:0]        wbm_adr_o,
   output logic [31:0]        wbm_dat_o,
   input  logic [31:0]        wbm_dat_i,
   input  logic               wbm_ack_i,
   // Status back to the probes
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [15:0]        err_count,
   output logic [31:0]        first_err_addr,
   output logic               timeout
);

   bist_state_e        state;
   logic [31:0]        base_q;    // word-aligned start address
   logic [31:0]        seed_q;    // seed kept for the read-back reload
   logic [COUNT_W-1:0] count_q;   // number of words under test
   logic [COUNT_W-1:0] idx;       // words completed in the current pass

   logic               lfsr_load;
   logic               lfsr_adv;
   logic [31:0]        lfsr_seed;
   logic [31:0]        lfsr_value;

`ifdef WB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0]   tmo_cnt;   // cycles spent waiting in the current request
`endif

   // Every access moves a full word.
   assign wbm_sel_o = WB_SEL_ALL;

   // The pattern register is a flop, so write data comes straight from it.
   assign wbm_dat_o = lfsr_value;

   sram_bist_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (lfsr_seed),
      .advance (lfsr_adv),
      .value   (lfsr_value)
   );

   // Pattern generator control: seed at start and before read-back, step on every ack.
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      lfsr_seed = seed_q;
      unique case (state)
         ST_IDLE: begin
            lfsr_seed = seed;
            lfsr_load = start && (count != '0);
         end
         ST_WR_GAP: begin
            lfsr_load = (idx == count_q);
         end
         ST_WR_REQ, ST_RD_REQ: begin
            lfsr_adv = wbm_ack_i;
         end
         default: begin
         end
      endcase
   end

   // Main sequencer: bus requests, address walk, compare and status update.
   // NOTE: all state here uses non-blocking assignments so every register
   // sees the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= ST_IDLE;
         base_q         <= 32'h0;
         seed_q         <= 32'h0;
         count_q        <= '0;
         idx            <= '0;
         wbm_cyc_o      <= 1'b0;
         wbm_stb_o      <= 1'b0;
         wbm_we_o       <= 1'b0;
         wbm_adr_o      <= 32'h0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 16'h0;
         first_err_addr <= 32'h0;
`ifdef WB_TIMEOUT_EN
         timeout        <= 1'b0;
         tmo_cnt        <= '0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q         <= base_addr & ADDR_ALIGN_MASK;
                  seed_q         <= seed;
                  count_q        <= count;
                  idx            <= '0;
                  wbm_adr_o      <= base_addr & ADDR_ALIGN_MASK;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= 16'h0;
                  first_err_addr <= 32'h0;
`ifdef WB_TIMEOUT_EN
                  timeout        <= 1'b0;
                  tmo_cnt        <= '0;
`endif
                  if (count == '0) begin
                     state <= ST_FIN;
                  end else begin
                     state     <= ST_WR_REQ;
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b1;
                  end
               end
            end

            ST_WR_REQ, ST_RD_REQ: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  idx       <= idx + COUNT_W'(1);
                  wbm_adr_o <= wbm_adr_o + WORD_STRIDE;
                  if (state == ST_RD_REQ && wbm_dat_i != lfsr_value) begin
                     if (err_count != ERR_COUNT_MAX) begin
                        err_count <= err_count + 16'd1;
                     end
                     // The counter saturates, so zero means no earlier error.
                     if (err_count == 16'h0) begin
                        first_err_addr <= wbm_adr_o;
                     end
                  end
                  state <= (state == ST_WR_REQ) ? ST_WR_GAP : ST_RD_GAP;
`ifdef WB_TIMEOUT_EN
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  // Responder never answered: abandon the cycle and fail.
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  timeout   <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= ST_FIN;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
               end
            end

            ST_WR_GAP: begin
               wbm_cyc_o <= 1'b1;
               wbm_stb_o <= 1'b1;
               if (idx == count_q) begin
                  // Write pass finished: restart the walk for read-back.
                  idx       <= '0;
                  wbm_adr_o <= base_q;
                  wbm_we_o  <= 1'b0;
                  state     <= ST_RD_REQ;
               end else begin
                  wbm_we_o  <= 1'b1;
                  state     <= ST_WR_REQ;
               end
            end

            ST_RD_GAP: begin
               if (idx == count_q) begin
                  state <= ST_FIN;
               end else begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  state     <= ST_RD_REQ;
               end
            end

            ST_FIN: begin
               done  <= 1'b1;
               pass  <= (err_count == 16'h0) && !timeout;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef WB_TIMEOUT_EN
   // Without the watchdog the master waits for ack forever and never times out.
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_bist_master.sv
// Self-checking bench for wb_sram_bist_master with a one-cycle-ack memory
// model. Define WB_TIMEOUT_EN for both bench and RTL to add the watchdog test.
module tb_wb_sram_bist_master;

   localparam int unsigned COUNT_W = 12;
   localparam int          LIMIT   = 2000;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [31:0]        base_addr = 32'h0;
   logic [COUNT_W-1:0] count = '0;
   logic [31:0]        seed = 32'h0;
   logic               wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]         wbm_sel_o;
   logic [31:0]        wbm_adr_o, wbm_dat_o;
   logic [31:0]        wbm_dat_i = 32'h0;
   logic               wbm_ack_i = 1'b0;
   logic               busy, done, pass, timeout;
   logic [15:0]        err_count;
   logic [31:0]        first_err_addr;

   int errors = 0;
   int checks = 0;

   // Memory model state and transaction log
   logic [31:0] mem [logic [31:0]];
   logic [31:0] log_adr [$];
   logic        log_we  [$];
   logic [31:0] log_dat [$];
   int          reads_acked = 0;
   int          cyc_seen = 0;
   bit          corrupt_en = 1'b0;
   bit          no_ack = 1'b0;

   // Hand-computed pattern for seed 1: 1, then successive Galois steps.
   logic [31:0] exp_pat [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};

   wb_sram_bist_master #(.COUNT_W(COUNT_W), .TIMEOUT_CYCLES(255)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_addr      (base_addr),
      .count          (count),
      .seed           (seed),
      .wbm_cyc_o      (wbm_cyc_o),
      .wbm_stb_o      (wbm_stb_o),
      .wbm_we_o       (wbm_we_o),
      .wbm_sel_o      (wbm_sel_o),
      .wbm_adr_o      (wbm_adr_o),
      .wbm_dat_o      (wbm_dat_o),
      .wbm_dat_i      (wbm_dat_i),
      .wbm_ack_i      (wbm_ack_i),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   // One-cycle-ack SRAM responder with optional read corruption at 0x8
   always @(posedge clk) begin
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !no_ack) begin
         wbm_ack_i <= 1'b1;
         log_adr.push_back(wbm_adr_o);
         log_we.push_back(wbm_we_o);
         if (wbm_we_o) begin
            mem[wbm_adr_o] = wbm_dat_o;
            log_dat.push_back(wbm_dat_o);
         end else begin
            logic [31:0] rd;
            rd = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'hDEAD_BEEF;
            if (corrupt_en && wbm_adr_o == 32'h8) rd = rd ^ 32'h1;
            wbm_dat_i <= rd;
            log_dat.push_back(rd);
            reads_acked++;
         end
      end else begin
         wbm_ack_i <= 1'b0;
      end
   end

   // Count cycles during which a bus cycle is open
   always @(negedge clk) begin
      if (wbm_cyc_o) cyc_seen++;
   end

   task automatic clear_log();
      log_adr.delete();
      log_we.delete();
      log_dat.delete();
      reads_acked = 0;
      cyc_seen = 0;
   endtask

   // Pulse start and count edges (start-sampling edge = 1) until done.
   task automatic run_bist(input logic [31:0] base, input logic [COUNT_W-1:0] cnt,
                           input logic [31:0] sd, input bit poke, output int cycles);
      clear_log();
      @(negedge clk);
      base_addr = base;
      count = cnt;
      seed = sd;
      start = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         start = poke && (cycles == 5);
         count = (poke && cycles == 5) ? COUNT_W'(1) : cnt;
      end while (!done && cycles < LIMIT);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wbm_cyc_o); end
      checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wbm_stb_o); end
      checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wbm_we_o); end
      checks++; if (wbm_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h want f", wbm_sel_o); end
      checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", wbm_adr_o); end
      checks++; if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", wbm_dat_o); end
      checks++; if ({busy, done, pass, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, timeout}); end
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count: got %h want 0", err_count); end
      checks++; if (first_err_addr !== 32'h0) begin errors++; $display("FAIL reset_first_err: got %h want 0", first_err_addr); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cycles;
      run_bist(32'h0, 4, 32'h1, 1'b0, cycles);
      checks++; if (cycles !== 26) begin errors++; $display("FAIL basic_latency: got %0d want 26", cycles); end
      checks++; if (log_adr.size() !== 8) begin errors++; $display("FAIL basic_xfers: got %0d want 8", log_adr.size()); end
      for (int i = 0; i < 8; i++) begin
         if (i < log_adr.size()) begin
            checks++; if (log_adr[i] !== 32'(4 * (i % 4))) begin errors++; $display("FAIL basic_adr%0d: got %h want %h", i, log_adr[i], 32'(4 * (i % 4))); end
            checks++; if (log_we[i] !== (i < 4)) begin errors++; $display("FAIL basic_we%0d: got %b want %b", i, log_we[i], (i < 4)); end
            if (i < 4) begin
               checks++; if (log_dat[i] !== exp_pat[i]) begin errors++; $display("FAIL basic_wdat%0d: got %h want %h", i, log_dat[i], exp_pat[i]); end
            end
         end
      end
      checks++; if ({done, pass, busy} !== 3'b110) begin errors++; $display("FAIL basic_status: got done/pass/busy=%b want 110", {done, pass, busy}); end
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL basic_err_count: got %0d want 0", err_count); end
      checks++; if (first_err_addr !== 32'h0) begin errors++; $display("FAIL basic_first_err: got %h want 0", first_err_addr); end
   endtask

   task automatic test_corrupt();
      int cycles;
      corrupt_en = 1'b1;
      run_bist(32'h0, 4, 32'h1, 1'b0, cycles);
      corrupt_en = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL corrupt_done: got %b want 1", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b want 0", pass); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL corrupt_err_count: got %0d want 1", err_count); end
      checks++; if (first_err_addr !== 32'h8) begin errors++; $display("FAIL corrupt_first_err: got %h want 8", first_err_addr); end
   endtask

   task automatic test_count_zero();
      int cycles;
      run_bist(32'h20, 0, 32'h5, 1'b0, cycles);
      checks++; if (cycles > 2) begin errors++; $display("FAIL zero_latency: got %0d want <=2", cycles); end
      checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL zero_status: got done/pass=%b want 11", {done, pass}); end
      checks++; if (cyc_seen !== 0) begin errors++; $display("FAIL zero_no_cyc: got %0d cyc cycles want 0", cyc_seen); end
   endtask

   task automatic test_seed_zero();
      int cycles;
      run_bist(32'h40, 1, 32'h0, 1'b0, cycles);
      checks++; if (cycles !== 8) begin errors++; $display("FAIL seed0_latency: got %0d want 8", cycles); end
      checks++; if (log_dat.size() < 1 || log_dat[0] !== 32'h1) begin errors++; $display("FAIL seed0_wdat: got %h want 00000001", (log_dat.size() > 0) ? log_dat[0] : 32'hx); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL seed0_pass: got %b want 1", pass); end
   endtask

   task automatic test_wrap();
      int cycles;
      logic [31:0] exp_adr [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      run_bist(32'hFFFF_FFFA, 4, 32'hACE1_1234, 1'b0, cycles);
      checks++; if (log_adr.size() !== 8) begin errors++; $display("FAIL wrap_xfers: got %0d want 8", log_adr.size()); end
      for (int i = 0; i < 8; i++) begin
         if (i < log_adr.size()) begin
            checks++; if (log_adr[i] !== exp_adr[i % 4]) begin errors++; $display("FAIL wrap_adr%0d: got %h want %h", i, log_adr[i], exp_adr[i % 4]); end
         end
      end
      checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL wrap_status: got done/pass=%b want 11", {done, pass}); end
   endtask

   task automatic test_back_to_back();
      int cycles;
      // A second start (with a different count) lands while busy and must be ignored.
      run_bist(32'h0, 4, 32'h1, 1'b1, cycles);
      checks++; if (cycles !== 26) begin errors++; $display("FAIL busy_start_latency: got %0d want 26", cycles); end
      checks++; if (log_adr.size() !== 8) begin errors++; $display("FAIL busy_start_xfers: got %0d want 8", log_adr.size()); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL busy_start_pass: got %b want 1", pass); end
   endtask

   task automatic test_mid_reset();
      int n;
      int cycles;
      clear_log();
      @(negedge clk);
      base_addr = 32'h100;
      count = 4;
      seed = 32'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(reads_acked == 2 && wbm_cyc_o && !wbm_we_o) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 500) begin errors++; $display("FAIL midrst_wait: third read not seen after %0d cycles", n); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL midrst_cyc: got %b want 0", wbm_cyc_o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
      checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL midrst_adr: got %h want 0", wbm_adr_o); end
      rst = 1'b1;
      run_bist(32'h0, 4, 32'h1, 1'b0, cycles);
      checks++; if (cycles !== 26) begin errors++; $display("FAIL midrst_rerun_latency: got %0d want 26", cycles); end
      checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL midrst_rerun_status: got done/pass=%b want 11", {done, pass}); end
   endtask

   task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
      int cycles;
      no_ack = 1'b1;
      run_bist(32'h0, 2, 32'h1, 1'b0, cycles);
      no_ack = 1'b0;
      checks++; if (cyc_seen !== 255) begin errors++; $display("FAIL tmo_cyc_len: got %0d want 255", cyc_seen); end
      checks++; if ({done, timeout, pass} !== 3'b110) begin errors++; $display("FAIL tmo_status: got done/timeout/pass=%b want 110", {done, timeout, pass}); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corrupt();
      test_count_zero();
      test_seed_zero();
      test_wrap();
      test_back_to_back();
      test_mid_reset();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
